// File: rtl/codes.sv
// codes: shared opcodes, memory-unit FSM states and bus types.
package codes;
  localparam int SIZE = 32;
  typedef logic [SIZE-1:0] size_t;
  typedef logic [3:0] byteenable_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
  } opcode_t;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, DONE, FAULT} mem_state_t;
  function automatic logic is_load(opcode_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction
  function automatic logic is_store(opcode_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering, byte enables, load extension and alignment check.
module mem_lane_align
  import codes::*;
(
  input  opcode_t     opcode,
  input  logic [1:0]  offset,
  input  size_t       write_data,
  input  size_t       read_data,
  output byteenable_t byteenable,
  output size_t       writedata,
  output size_t       load_data,
  output logic        misaligned
);
  logic is_byte, is_half, is_word;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;
  always_comb begin
    is_byte = opcode inside {OP_LB, OP_LBU, OP_SB};
    is_half = opcode inside {OP_LH, OP_LHU, OP_SH};
    is_word = opcode inside {OP_LW, OP_SW};
    misaligned = (is_half && offset[0]) || (is_word && offset != 2'b00);
    byteenable = is_byte ? 4'b0001 << offset
               : is_half ? (offset[1] ? 4'b1100 : 4'b0011)
               : is_word ? 4'b1111 : 4'b0000;
    writedata = !is_store(opcode) ? '0
              : is_byte ? {24'b0, write_data[31:24]} << {offset, 3'b000}
              : is_half ? (offset[1] ? {write_data[31:16], 16'b0} : {16'b0, write_data[31:16]})
              : write_data;
    rd_byte = read_data[{offset, 3'b000} +: 8];
    rd_half = offset[1] ? read_data[31:16] : read_data[15:0];
    load_data = opcode == OP_LB  ? {{24{rd_byte[7]}}, rd_byte}
              : opcode == OP_LBU ? {24'b0, rd_byte}
              : opcode == OP_LH  ? {{16{rd_half[15]}}, rd_half}
              : opcode == OP_LHU ? {16'b0, rd_half}
              : read_data;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store master for an Avalon-style data port.
module mem_access_unit
  import codes::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start_i,
  input  opcode_t     opcode_i,
  input  size_t       address_i,
  input  size_t       write_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output size_t       load_data_o,
  output size_t       avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output byteenable_t avm_byteenable_o,
  output size_t       avm_writedata_o,
  input  logic        avm_waitrequest_i,
  input  size_t       avm_readdata_i
);
  mem_state_t state;
  opcode_t op_q, al_op;
  logic [1:0] off_q, al_off;
  byteenable_t al_be;
  size_t al_wdata, al_load;
  logic al_mis, accept;
  // In IDLE the aligner sees the live request; afterwards it sees the captured one.
  assign al_op = state == IDLE ? opcode_i : op_q;
  assign al_off = state == IDLE ? address_i[1:0] : off_q;
  assign accept = state == IDLE && start_i && (is_load(opcode_i) || is_store(opcode_i));
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign fault_o = state == FAULT;
  mem_lane_align u_align (
    .opcode    (al_op),
    .offset    (al_off),
    .write_data(write_data_i),
    .read_data (avm_readdata_i),
    .byteenable(al_be),
    .writedata (al_wdata),
    .load_data (al_load),
    .misaligned(al_mis)
  );
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= IDLE;
      op_q <= OP_NOP;
      off_q <= '0;
      load_data_o <= '0;
      avm_address_o <= '0;
      avm_byteenable_o <= '0;
      avm_writedata_o <= '0;
      avm_read_o <= 1'b0;
      avm_write_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= opcode_i;
          off_q <= address_i[1:0];
          if (al_mis) state <= FAULT;
          else begin
            state <= is_load(opcode_i) ? RD_REQ : WR_REQ;
            avm_address_o <= {address_i[31:2], 2'b00};
            avm_byteenable_o <= al_be;
            avm_writedata_o <= al_wdata;
            avm_read_o <= is_load(opcode_i);
            avm_write_o <= is_store(opcode_i);
          end
        end
        RD_REQ: if (!avm_waitrequest_i) begin
          state <= RD_DATA;
          avm_read_o <= 1'b0;
        end
        WR_REQ: if (!avm_waitrequest_i) begin
          state <= DONE;
          avm_write_o <= 1'b0;
        end
        RD_DATA: begin
          load_data_o <= al_load;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store bus master between the CPU datapath and the Avalon-style data memory port. Takes a single memory request (opcode, effective address, left-justified store data), performs alignment checking, byte-lane steering and byte-enable generation, runs the bus handshake including `waitrequest` stalls, and returns right-justified, sign- or zero-extended load data. One transaction in flight at a time; the CPU control FSM stalls on `busy_o`.

## Interface
Parameters:
- none. Data and address width are fixed at 32 via `size_t`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge. One clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request strobe; sampled only in IDLE.
- `opcode_i`  in  `opcode_t`  one of OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW.
- `address_i`  in  32  effective byte address.
- `write_data_i`  in  32  store data, left-justified: byte in [31:24], half in [31:16], word in [31:0].
- `busy_o`  out  1  high in every non-IDLE state.
- `done_o`  out  1  one-cycle pulse on completion.
- `fault_o`  out  1  one-cycle pulse on misaligned request.
- `load_data_o`  out  32  extended load result; held until the next load completes.
- `avm_address_o`  out  32  word-aligned address, bits [1:0] always 0.
- `avm_read_o`, `avm_write_o`  out  1  bus commands, mutually exclusive.
- `avm_byteenable_o`  out  4  active lanes.
- `avm_writedata_o`  out  32  lane-steered store data; unused lanes 0.
- `avm_waitrequest_i`  in  1  slave stall.
- `avm_readdata_i`  in  32  read data, valid exactly one cycle after read acceptance.

## Operation
- Little-endian lanes: byte at offset k = `address_i[1:0]` occupies bits [8k+7:8k].
- Alignment: half accesses require `address_i[0]`=0. Word accesses require `address_i[1:0]`=0. Byte accesses are always aligned.
- Byte-enable: byte = 1<<k. Half at offset 0 = 0011, at offset 2 = 1100. Word = 1111. Loads drive the same enables.
- Store steering: SB puts `write_data_i[31:24]` into lane k. SH puts `write_data_i[31:16]` into lanes {1,0} or {3,2}. SW passes data through.
- Load extraction: LB/LH sign-extend the selected lane(s). LBU/LHU zero-extend. LW passes data through.
- FSM states:
  - IDLE: on `start_i` with a memory opcode:
    - misaligned → FAULT;
    - load → RD_REQ;
    - store → WR_REQ.
    - A non-memory opcode is ignored, with no pulse.
  - Opcode, address and data are registered in IDLE; inputs are don't-care afterwards.
  - RD_REQ: `avm_read_o`=1. When `avm_waitrequest_i`=0 → RD_DATA.
  - RD_DATA: bus idle. Capture and extend `avm_readdata_i` into `load_data_o` → DONE.
  - WR_REQ: `avm_write_o`=1. When `avm_waitrequest_i`=0 → DONE.
  - DONE: `done_o`=1 → IDLE.
  - FAULT: `fault_o`=1, no bus activity → IDLE.
- `start_i` outside IDLE is ignored; it is not queued.
- Bus outputs stay stable throughout a stall.

## Timing
- Reset values: state IDLE, `busy_o`/`done_o`/`fault_o`/`avm_read_o`/`avm_write_o` = 0, `avm_byteenable_o`=0, `avm_address_o`=0, `avm_writedata_o`=0, `load_data_o`=0.
- Cycle 0 = the cycle `start_i` is sampled in IDLE. The command is asserted from cycle 1. With W wait cycles, acceptance is at cycle 1+W.
- Store: `done_o` at cycle 2+W. Minimum latency 2.
- Load: readdata sampled at cycle 2+W, `done_o` and valid `load_data_o` at cycle 3+W. Minimum latency 3.
- Fault: `fault_o` at cycle 1.
- Back-to-back: a new `start_i` is accepted in the cycle after `done_o`/`fault_o`, i.e. IDLE is re-entered.
- Reset mid-transaction: the next edge forces IDLE and deasserts commands. An abandoned read's readdata is never captured.
- Unbounded `waitrequest` is legal; there is no timeout.

## Structure
- `codes` package gains:
  - OP_LBU, OP_LHU if absent;
  - `typedef enum logic [2:0] mem_state_t` {IDLE, RD_REQ, RD_DATA, WR_REQ, DONE, FAULT};
  - `typedef logic [3:0] byteenable_t`.
- One combinational sub-module: `mem_lane_align`.
  - Inputs: opcode, offset, write data, read data.
  - Outputs: byteenable, steered writedata, extended load data, misaligned flag.
  - The top level holds the FSM and registers.

## Test plan
- SB, addr 0x1003, data 0xAB000000, no wait → cycle 1: address 0x1000, BE 1000, writedata 0xAB000000; `done_o` at cycle 2.
- LB, addr 0x2001, readdata 0x0000_8000 → `load_data_o` 0xFFFFFF80 at cycle 3. Same with LBU → 0x00000080.
- LH, addr 0x2002, readdata 0x1234_5678, 3 waitrequest cycles → BE 1100 held 4 cycles; `load_data_o` 0x00001234 with `done_o` at cycle 6.
- SW, addr 0x0006 → `fault_o` at cycle 1, `avm_write_o` never high. LH at 0x0001 also faults.
- `reset_i` asserted during RD_REQ stall → next cycle IDLE, `avm_read_o`=0, no `done_o`, `load_data_o`=0.
- `start_i` held high while busy, then SW 0x4 data 0xDEADBEEF right after `done_o` → only two transactions; second has BE 1111, writedata 0xDEADBEEF.
